// File: rtl/tlp_pkg.sv
// Shared TLP-path definitions: scheduler state encoding and default widths
// used by the flow-control FSM, the VC FIFOs and the VC scheduler.
package tlp_pkg;

  localparam int NUM_VC_DEF = 4;
  localparam int DATA_W_DEF = 10;

  // One-hot scheduler states.
  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_ARB    = 4'b0010,
    S_SERVE  = 4'b0100,
    S_PAUSED = 4'b1000
  } sched_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: grants the first asserted request found when
// searching upward from ptr, wrapping modulo NUM_VC.
module rr_priority_pick #(
  parameter int NUM_VC = 4,
  parameter int PTR_W  = $clog2(NUM_VC)
) (
  input  logic [NUM_VC-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_VC-1:0] gnt,
  output logic [PTR_W-1:0]  gnt_idx,
  output logic              any_req
);

  // cand[gi] is the request index examined at search offset gi.
  logic [PTR_W-1:0] cand [NUM_VC];

  generate
    for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_cand
      logic [PTR_W:0] sum_w;
      assign sum_w     = {1'b0, ptr} + (PTR_W+1)'(gi);
      assign cand[gi]  = (sum_w >= (PTR_W+1)'(NUM_VC)) ?
                         PTR_W'(sum_w - (PTR_W+1)'(NUM_VC)) : PTR_W'(sum_w);
    end
  endgenerate

  always_comb begin
    logic found;
    found   = 1'b0;
    gnt     = '0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (!found && req[cand[i]]) begin
        found        = 1'b1;
        gnt[cand[i]] = 1'b1;
        gnt_idx      = cand[i];
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/tlp_vc_scheduler.sv
// Round-robin scheduler draining per-VC TLP FIFOs into one output FIFO with
// bounded bursts per grant, downstream pause handling and a sticky overflow flag.
module tlp_vc_scheduler
  import tlp_pkg::*;
#(
  parameter int NUM_VC  = NUM_VC_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int QUANTUM = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_VC-1:0]        vc_empty,
  input  logic [NUM_VC*DATA_W-1:0] vc_data,
  output logic [NUM_VC-1:0]        vc_pop,
  input  logic                     out_pause,
  input  logic                     out_full,
  output logic                     out_push,
  output logic [DATA_W-1:0]        out_data,
  output logic [NUM_VC-1:0]        grant,
  output logic                     idle,
  output logic                     error_full
);

  localparam int PTR_W = $clog2(NUM_VC);
  localparam int CNT_W = $clog2(QUANTUM + 1);

  sched_state_t        state_reg, state_next;
  logic [PTR_W-1:0]    ptr_reg, ptr_next;
  logic [CNT_W-1:0]    burst_cnt_reg, burst_cnt_next;
  logic [NUM_VC-1:0]   grant_reg, grant_next;
  logic [PTR_W-1:0]    grant_idx_reg, grant_idx_next;
  logic                pend_reg;
  logic [NUM_VC-1:0]   pop_sel_reg;
  logic                error_full_reg;

  logic [NUM_VC-1:0]   req_vec;
  logic [NUM_VC-1:0]   pick_gnt;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_any;
  logic                grant_empty;
  logic                leave_grant;
  logic [PTR_W-1:0]    ptr_after_grant;

  assign req_vec = ~vc_empty;

  rr_priority_pick #(
    .NUM_VC (NUM_VC),
    .PTR_W  (PTR_W)
  ) u_pick (
    .req     (req_vec),
    .ptr     (ptr_reg),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any_req (pick_any)
  );

  assign grant_empty     = |(grant_reg & vc_empty);
  assign ptr_after_grant = (grant_idx_reg == PTR_W'(NUM_VC - 1)) ? '0
                                                                 : grant_idx_reg + PTR_W'(1);

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    burst_cnt_next = burst_cnt_reg;
    grant_next     = grant_reg;
    grant_idx_next = grant_idx_reg;
    vc_pop         = '0;
    leave_grant    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (enable && pick_any) state_next = S_ARB;
      end
      S_ARB: begin
        if (enable && pick_any) begin
          grant_next     = pick_gnt;
          grant_idx_next = pick_idx;
          burst_cnt_next = '0;
          state_next     = S_SERVE;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_SERVE: begin
        // Event priority: enable drop, then pause, then empty, then quantum.
        if (!enable) begin
          leave_grant = 1'b1;
        end else if (out_pause) begin
          if (!grant_empty) state_next  = S_PAUSED;
          else              leave_grant = 1'b1;
        end else if (grant_empty) begin
          leave_grant = 1'b1;
        end else begin
          vc_pop         = grant_reg;
          burst_cnt_next = burst_cnt_reg + CNT_W'(1);
          if (burst_cnt_reg == CNT_W'(QUANTUM - 1)) leave_grant = 1'b1;
        end
      end
      S_PAUSED: begin
        if (!enable)         leave_grant = 1'b1;
        else if (!out_pause) state_next  = S_SERVE;
      end
      default: state_next = S_IDLE;
    endcase

    if (leave_grant) begin
      state_next = S_ARB;
      ptr_next   = ptr_after_grant;
      grant_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      ptr_reg        <= '0;
      burst_cnt_reg  <= '0;
      grant_reg      <= '0;
      grant_idx_reg  <= '0;
      pend_reg       <= 1'b0;
      pop_sel_reg    <= '0;
      error_full_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      burst_cnt_reg <= burst_cnt_next;
      grant_reg     <= grant_next;
      grant_idx_reg <= grant_idx_next;
      pend_reg      <= |vc_pop;
      pop_sel_reg   <= vc_pop;
      if (pend_reg && out_full) error_full_reg <= 1'b1;
    end
  end

  // FIFO read data arrives the cycle after the pop, so the word is steered
  // by the registered pop select; an empty select yields zero.
  logic [DATA_W-1:0] data_terms [NUM_VC];

  generate
    for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_data
      assign data_terms[gi] = pop_sel_reg[gi] ? vc_data[gi*DATA_W +: DATA_W] : '0;
    end
  endgenerate

  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM_VC; i++) out_data = out_data | data_terms[i];
  end

  assign out_push   = pend_reg & ~out_full;
  assign grant      = grant_reg;
  assign idle       = (state_reg == S_IDLE) & ~pend_reg;
  assign error_full = error_full_reg;

endmodule

// File: tb/tb_tlp_vc_scheduler.sv
// Self-checking bench for tlp_vc_scheduler: FIFO models plus a cycle-level
// behavioural reference, directed scenarios and a randomized soak.
module tb_tlp_vc_scheduler;

  localparam int NV = 4;
  localparam int DW = 10;
  localparam int Q  = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b0;
  logic [NV-1:0]   vc_empty = '1;
  logic [NV*DW-1:0] vc_data = '0;
  logic [NV-1:0]   vc_pop;
  logic            out_pause = 1'b0;
  logic            out_full = 1'b0;
  logic            out_push;
  logic [DW-1:0]   out_data;
  logic [NV-1:0]   grant;
  logic            idle;
  logic            error_full;

  always #5 clk = ~clk;

  tlp_vc_scheduler #(.NUM_VC(NV), .DATA_W(DW), .QUANTUM(Q)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .vc_empty   (vc_empty),
    .vc_data    (vc_data),
    .vc_pop     (vc_pop),
    .out_pause  (out_pause),
    .out_full   (out_full),
    .out_push   (out_push),
    .out_data   (out_data),
    .grant      (grant),
    .idle       (idle),
    .error_full (error_full)
  );

  int checks = 0;
  int errors = 0;

  // VC FIFO contents (circular buffers); words are {vc, sequence}.
  logic [DW-1:0] fmem [NV][256];
  int            fcnt [NV];
  int            fhead [NV];
  int            seqn [NV];
  logic [DW-1:0] data_next [NV];
  logic [NV-1:0] data_upd = '0;

  // Reference model: phase 0 idle, 1 choosing, 2 serving, 3 paused.
  int            m_phase, m_ptr, m_owner, m_cnt;
  bit            m_pend, m_err;
  logic [DW-1:0] m_word;

  int            push_log [$];
  logic [NV-1:0] s_pop, s_grant;
  logic          s_push, s_idle, s_err;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic load(input int vc, input int n);
    for (int i = 0; i < n; i++) begin
      if (fcnt[vc] < 250) begin
        fmem[vc][(fhead[vc] + fcnt[vc]) % 256] = {2'(vc), 8'(seqn[vc])};
        seqn[vc]++;
        fcnt[vc]++;
      end
    end
  endtask

  function automatic bit fifos_empty();
    for (int k = 0; k < NV; k++) if (fcnt[k] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_owner = -1; m_cnt = 0;
    m_pend = 1'b0; m_err = 1'b0; m_word = '0;
  endtask

  task automatic step(input bit en, input bit ps, input bit fl);
    logic [NV-1:0] ep, eg;
    bit            any_ne, owner_empty, release_owner;
    logic [DW-1:0] word_next;

    @(negedge clk);
    enable = en; out_pause = ps; out_full = fl;
    for (int k = 0; k < NV; k++) begin
      if (data_upd[k]) vc_data[k*DW +: DW] = data_next[k];
      vc_empty[k] = (fcnt[k] == 0);
    end
    data_upd = '0;
    #1;

    ep = '0;
    eg = (m_owner >= 0) ? NV'(1 << m_owner) : '0;
    any_ne = (vc_empty != '1);
    owner_empty = (m_owner >= 0) ? vc_empty[m_owner] : 1'b1;
    release_owner = 1'b0;
    word_next = '0;

    case (m_phase)
      0: if (en && any_ne) m_phase = 1;
      1: begin
        if (en && any_ne) begin
          for (int i = NV - 1; i >= 0; i--)
            if (!vc_empty[(m_ptr + i) % NV]) m_owner = (m_ptr + i) % NV;
          m_cnt = 0;
          m_phase = 2;
        end else m_phase = 0;
      end
      2: begin
        if (!en) release_owner = 1'b1;
        else if (ps) begin
          if (!owner_empty) m_phase = 3; else release_owner = 1'b1;
        end else if (owner_empty) release_owner = 1'b1;
        else begin
          ep = NV'(1 << m_owner);
          word_next = fmem[m_owner][fhead[m_owner]];
          m_cnt++;
          if (m_cnt == Q) release_owner = 1'b1;
        end
      end
      default: begin
        if (!en) release_owner = 1'b1;
        else if (!ps) m_phase = 2;
      end
    endcase

    chk("vc_pop", int'(vc_pop), int'(ep));
    chk("grant", int'(grant), int'(eg));
    chk("out_push", int'(out_push), int'(m_pend && !fl));
    if (m_pend && !fl && out_push) chk("out_data", int'(out_data), int'(m_word));
    chk("idle", int'(idle), int'(m_phase_was_idle(eg) && !m_pend));
    chk("error_full", int'(error_full), int'(m_err));

    s_pop = vc_pop; s_grant = grant; s_push = out_push; s_idle = idle; s_err = error_full;
    if (out_push) begin
      push_log.push_back(int'(out_data[DW-1:8]));
      $display("push vc=%0d seq=%0d grant=%b", out_data[DW-1:8], out_data[7:0], grant);
    end

    if (release_owner) begin
      m_ptr = (m_owner + 1) % NV;
      m_owner = -1;
      m_phase = 1;
    end
    if (m_pend && fl) m_err = 1'b1;
    m_pend = (ep != '0);
    if (ep != '0) m_word = word_next;

    for (int k = 0; k < NV; k++) begin
      if (vc_pop[k] && fcnt[k] > 0) begin
        data_next[k] = fmem[k][fhead[k]];
        data_upd[k] = 1'b1;
        fhead[k] = (fhead[k] + 1) % 256;
        fcnt[k]--;
      end
    end
  endtask

  // Idle is judged on the phase as it stood when the cycle began.
  bit phase_idle_at_start;
  function automatic bit m_phase_was_idle(input logic [NV-1:0] unused_g);
    return phase_idle_at_start;
  endfunction

  task automatic stepc(input bit en, input bit ps, input bit fl);
    phase_idle_at_start = (m_phase == 0);
    step(en, ps, fl);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1; enable = 1'b0; out_pause = 1'b0; out_full = 1'b0;
    data_upd = '0;
    for (int k = 0; k < NV; k++) vc_empty[k] = (fcnt[k] == 0);
    repeat (n) @(negedge clk);
    #1;
    chk("rst_vc_pop", int'(vc_pop), 0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_out_push", int'(out_push), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_idle", int'(idle), 1);
    chk("rst_error_full", int'(error_full), 0);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic drain(input int maxc);
    int c;
    c = 0;
    do begin
      stepc(1'b1, 1'b0, 1'b0);
      c++;
    end while (!(fifos_empty() && s_idle && m_phase == 0) && c < maxc);
    if (c >= maxc) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d cycles required fewer than %0d", c, maxc);
    end
  endtask

  task automatic chk_log(input string nm, input int exp_q [$]);
    chk({nm, "_len"}, push_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < push_log.size(); i++)
      chk(nm, push_log[i], exp_q[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops, base, c;
    for (int k = 0; k < NV; k++) begin fcnt[k] = 0; fhead[k] = 0; seqn[k] = 0; end
    model_reset();

    // Reset with all VCs non-empty; first grant must be VC0.
    for (int k = 0; k < NV; k++) load(k, 1);
    do_reset(2);
    repeat (3) stepc(1'b1, 1'b0, 1'b0);
    chk("first_grant", int'(grant), 1);
    drain(100);

    // Fairness across VC0 and VC2.
    do_reset(1);
    push_log.delete();
    load(0, 6); load(2, 6);
    drain(200);
    chk_log("fair_order", '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 2, 2});
    chk("fair_idle", int'(s_idle), 1);

    // Short queue, then confirm the pointer wrapped to VC0.
    do_reset(1);
    push_log.delete();
    load(1, 1); load(3, 5);
    drain(200);
    chk_log("short_order", '{1, 3, 3, 3, 3, 3});
    push_log.delete();
    load(2, 1); load(0, 1);
    drain(100);
    chk_log("ptr_wrap_order", '{0, 2});

    // Pause after two pops on VC2.
    do_reset(1);
    push_log.delete();
    load(2, 6);
    repeat (4) stepc(1'b1, 1'b0, 1'b0);
    base = push_log.size();
    repeat (4) stepc(1'b1, 1'b1, 1'b0);
    chk("pause_pushes", push_log.size() - base, 1);
    chk("pause_grant", int'(s_grant), 4);
    pops = 0; c = 0;
    do begin
      stepc(1'b1, 1'b0, 1'b0);
      if (s_pop == 4'b0100) pops++;
      c++;
    end while (s_grant != '0 && c < 20);
    chk("pause_resume_pops", pops, 2);
    drain(100);

    // Overflow: out_full in the cycle after a pop.
    do_reset(1);
    load(1, 3);
    c = 0;
    do begin stepc(1'b1, 1'b0, 1'b0); c++; end while (s_pop == '0 && c < 20);
    stepc(1'b1, 1'b0, 1'b1);
    chk("ovf_push", int'(s_push), 0);
    stepc(1'b1, 1'b0, 1'b0);
    chk("ovf_flag", int'(s_err), 1);
    drain(100);
    chk("ovf_sticky", int'(s_err), 1);

    // Enable drop mid-burst on VC0.
    do_reset(1);
    load(0, 5);
    repeat (4) stepc(1'b1, 1'b0, 1'b0);
    stepc(1'b0, 1'b0, 1'b0);
    chk("drop_push", int'(s_push), 1);
    repeat (3) stepc(1'b0, 1'b0, 1'b0);
    chk("drop_idle", int'(s_idle), 1);
    load(1, 2);
    repeat (3) stepc(1'b1, 1'b0, 1'b0);
    chk("drop_regrant", int'(s_grant), 2);
    drain(200);

    // Randomized soak.
    do_reset(1);
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 9) < 3) load($urandom_range(0, NV - 1), $urandom_range(1, 3));
      stepc($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
      if (n % 900 == 899) do_reset(1);
    end
    drain(2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
